// File: rtl/md_alu.sv
// Combinational ALU plus a multi-cycle multiply/divide unit with HI/LO registers.
// Define MD_ALU_DIV_EN to build the divider (DIV/DIVU); otherwise those MDOp codes are ignored.
module md_alu #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALUOp,
  output logic [WIDTH-1:0] res,
  input  logic [2:0]       MDOp,
  input  logic             start,
  output logic             busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int SHW    = $clog2(WIDTH);
  localparam int MAXLAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW     = $clog2(MAXLAT + 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             sgn_q, sgn_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;

  logic [SHW-1:0]   sh;
  assign sh = A[SHW-1:0];

  always_comb begin
    res = '0;
    case (ALUOp)
      4'b0000: res = A + B;
      4'b0001: res = A - B;
      4'b0010: res = A & B;
      4'b0011: res = A | B;
      4'b0100: res = {B[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      4'b0101: res = A ^ B;
      4'b0110: res = ~(A | B);
      4'b0111: res = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
      4'b1000: res = {{(WIDTH-1){1'b0}}, A < B};
      4'b1001: res = B << sh;
      4'b1010: res = B >> sh;
      4'b1011: res = $signed(B) >>> sh;
      default: res = '0;
    endcase
  end

  // Sign- or zero-extend to 2*WIDTH so one unsigned multiplier serves MULT and MULTU.
  logic [2*WIDTH-1:0] a_ext, b_ext, prod;
  always_comb begin
    a_ext = sgn_q ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    b_ext = sgn_q ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    prod  = a_ext * b_ext;
  end

`ifdef MD_ALU_DIV_EN
  // Divide magnitudes, then restore signs: quotient toward zero, remainder follows dividend.
  logic [WIDTH-1:0] a_mag, b_mag, q_mag, r_mag, quo, rem;
  logic             div_zero;
  always_comb begin
    a_mag    = (sgn_q && a_q[WIDTH-1]) ? -a_q : a_q;
    b_mag    = (sgn_q && b_q[WIDTH-1]) ? -b_q : b_q;
    div_zero = (b_q == '0);
    q_mag    = div_zero ? '0 : a_mag / b_mag;
    r_mag    = div_zero ? '0 : a_mag % b_mag;
    quo      = (sgn_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? -q_mag : q_mag;
    rem      = (sgn_q && a_q[WIDTH-1]) ? -r_mag : r_mag;
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          case (MDOp)
            3'b001, 3'b010: begin
              state_d = MUL;
              cnt_d   = CW'(MUL_LAT);
              a_d     = A;
              b_d     = B;
              sgn_d   = (MDOp == 3'b001);
            end
`ifdef MD_ALU_DIV_EN
            3'b011, 3'b100: begin
              state_d = DIV;
              cnt_d   = CW'(DIV_LAT);
              a_d     = A;
              b_d     = B;
              sgn_d   = (MDOp == 3'b011);
            end
`endif
            3'b101:  hi_d = A;
            3'b110:  lo_d = A;
            default: ;
          endcase
        end
      end
      MUL: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d      = IDLE;
          {hi_d, lo_d} = prod;
        end
      end
`ifdef MD_ALU_DIV_EN
      DIV: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          if (!div_zero) begin
            hi_d = rem;
            lo_d = quo;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_md_alu.sv
// Directed bench for md_alu: ALU vector table plus hand-written multiply/divide sequences.
module tb_md_alu;
  localparam int W  = 32;
  localparam int ML = 5;
  localparam int DL = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic [W-1:0]  A, B, res, HI, LO;
  logic [3:0]    ALUOp;
  logic [2:0]    MDOp;
  logic          start, busy;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] mh, ml;

  md_alu #(.WIDTH(W), .MUL_LAT(ML), .DIV_LAT(DL)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .ALUOp(ALUOp), .res(res),
    .MDOp(MDOp), .start(start), .busy(busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] e;
  } alu_vec_t;

  alu_vec_t vecs[17];

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
    end
  endtask

  task automatic run_md(input string nm, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int lat, input logic [W-1:0] eh,
                        input logic [W-1:0] el, input bit interfere);
    int n;
    bit held;
    MDOp = op; A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; MDOp = 3'b000;
    n = 0; held = 1'b1;
    while (busy && n < 200) begin
      if (HI !== mh || LO !== ml) held = 1'b0;
      if (interfere) begin
        A = $urandom; B = $urandom;
        start = (n == 0);
        MDOp  = (n == 0) ? 3'b001 : 3'b000;
      end
      n++;
      @(posedge clk); #1;
    end
    start = 1'b0; MDOp = 3'b000;
    chk({nm, " busy cycles"}, n, lat);
    chk({nm, " hold"}, {31'd0, held}, 32'd1);
    chk({nm, " HI"}, HI, eh);
    chk({nm, " LO"}, LO, el);
    mh = eh; ml = el;
  endtask

  task automatic reset_mid_op(input logic [2:0] op);
    MDOp = op; A = 32'd1000; B = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; MDOp = 3'b000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre-reset busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort HI", HI, 32'd0);
    chk("abort LO", LO, 32'd0);
    mh = '0; ml = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("post-abort busy", {31'd0, busy}, 32'd0);
    chk("post-abort LO", LO, 32'd0);
    run_md("mtlo after reset", 3'b110, 32'h1234, 32'd0, 0, 32'd0, 32'h1234, 1'b0);
  endtask

  initial begin
    vecs[0]  = '{4'b0000, 32'd5,          32'd7,          32'd12};
    vecs[1]  = '{4'b0000, 32'hFFFFFFFF,   32'd1,          32'd0};
    vecs[2]  = '{4'b0001, 32'd5,          32'd7,          32'hFFFFFFFE};
    vecs[3]  = '{4'b0010, 32'h0000F0F0,   32'h0000FF00,   32'h0000F000};
    vecs[4]  = '{4'b0011, 32'h0000F0F0,   32'h00000F00,   32'h0000FFF0};
    vecs[5]  = '{4'b0100, 32'd5,          32'h0000ABCD,   32'hABCD0000};
    vecs[6]  = '{4'b0101, 32'h0000FF00,   32'h00000FF0,   32'h0000F0F0};
    vecs[7]  = '{4'b0110, 32'hF0F0F0F0,   32'h0F0F0000,   32'h00000F0F};
    vecs[8]  = '{4'b0111, 32'd5,          32'h80000000,   32'd0};
    vecs[9]  = '{4'b0111, 32'hFFFFFFFF,   32'd1,          32'd1};
    vecs[10] = '{4'b1000, 32'd5,          32'h80000000,   32'd1};
    vecs[11] = '{4'b1001, 32'h00000024,   32'd1,          32'h00000010};
    vecs[12] = '{4'b1010, 32'd5,          32'h80000000,   32'h04000000};
    vecs[13] = '{4'b1011, 32'd5,          32'h80000000,   32'hFC000000};
    vecs[14] = '{4'b1111, 32'd5,          32'h80000000,   32'd0};
    vecs[15] = '{4'b1100, 32'd5,          32'd3,          32'd0};
    vecs[16] = '{4'b1011, 32'd4,          32'h7FFFFFF0,   32'h07FFFFFF};

    reset = 1'b1; start = 1'b0; MDOp = 3'b000; A = '0; B = '0; ALUOp = 4'b0000;
    mh = '0; ml = '0;
    #3;
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset HI", HI, 32'd0);
    chk("reset LO", LO, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 17; i++) begin
      A = vecs[i].a; B = vecs[i].b; ALUOp = vecs[i].op;
      #1;
      chk($sformatf("alu[%0d] op=%b", i, vecs[i].op), res, vecs[i].e);
    end

    run_md("mult -2*3", 3'b001, 32'hFFFFFFFE, 32'd3, ML, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0);
    run_md("multu ffffffff*2", 3'b010, 32'hFFFFFFFF, 32'd2, ML, 32'h00000001, 32'hFFFFFFFE, 1'b1);
    run_md("multu back2back", 3'b010, 32'h12345678, 32'h10, ML, 32'h00000001, 32'h23456780, 1'b0);
    run_md("mult -1*-1", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, ML, 32'd0, 32'd1, 1'b0);
    run_md("mthi", 3'b101, 32'hDEADBEEF, 32'd0, 0, 32'hDEADBEEF, 32'd1, 1'b0);
    run_md("mdop 000", 3'b000, 32'h55555555, 32'd9, 0, 32'hDEADBEEF, 32'd1, 1'b0);
    run_md("mdop 111", 3'b111, 32'h55555555, 32'd9, 0, 32'hDEADBEEF, 32'd1, 1'b0);

`ifdef MD_ALU_DIV_EN
    run_md("div -7/2", 3'b011, 32'hFFFFFFF9, 32'd2, DL, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run_md("divu 100/7", 3'b100, 32'd100, 32'd7, DL, 32'd2, 32'd14, 1'b1);
    run_md("divu by zero", 3'b100, 32'd55, 32'd0, DL, 32'd2, 32'd14, 1'b0);
    run_md("div min/-1", 3'b011, 32'h80000000, 32'hFFFFFFFF, DL, 32'd0, 32'h80000000, 1'b0);
    run_md("div 7/-2", 3'b011, 32'd7, 32'hFFFFFFFE, DL, 32'd1, 32'hFFFFFFFD, 1'b0);
    reset_mid_op(3'b011);
`else
    run_md("div disabled", 3'b011, 32'hFFFFFFF9, 32'd2, 0, 32'hDEADBEEF, 32'd1, 1'b0);
    run_md("divu disabled", 3'b100, 32'd100, 32'd7, 0, 32'hDEADBEEF, 32'd1, 1'b0);
    reset_mid_op(3'b001);
`endif

    run_md("mult after reset", 3'b001, 32'd6, 32'hFFFFFFF9, ML, 32'hFFFFFFFF, 32'hFFFFFFD6, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/md_alu.md
MD_ALU -- requirements
Module: md_alu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, datapath width; legal values are even and at least 16.
REQ-002 The block SHALL have parameter MUL_LAT, default 5, multiply busy cycles; legal values are at least 1.
REQ-003 The block SHALL have parameter DIV_LAT, default 10, divide busy cycles; legal values are at least 1.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port A, input, WIDTH bits: operand A; shift amount source; MTHI/MTLO data.
REQ-007 The block SHALL have port B, input, WIDTH bits: operand B.
REQ-008 The block SHALL have port ALUOp, input, 4 bits: combinational operation select.
REQ-009 The block SHALL have port res, output, WIDTH bits: combinational result.
REQ-010 The block SHALL have port MDOp, input, 3 bits: multiply/divide operation select.
REQ-011 The block SHALL have port start, input, 1 bit: launch strobe for MDOp.
REQ-012 The block SHALL have port busy, output, 1 bit: multi-cycle operation in flight.
REQ-013 The block SHALL have port HI, output, WIDTH bits: architectural HI register.
REQ-014 The block SHALL have port LO, output, WIDTH bits: architectural LO register.

Function
REQ-015 res SHALL be purely combinational from A, B and ALUOp, with zero latency, independent of busy.
REQ-016 ALUOp SHALL decode as follows: 0000 A+B; 0001 A-B; 0010 A&B; 0011 A|B; 0100 {B[WIDTH/2-1:0], WIDTH/2 zeros}; 0101 A^B; 0110 ~(A|B); 0111 signed A<B (result 1/0); 1000 unsigned A<B; 1001 B<<sh; 1010 B>>sh logical; 1011 B>>>sh arithmetic.
REQ-017 The shift amount sh SHALL be A[$clog2(WIDTH)-1:0].
REQ-018 Add and subtract SHALL wrap modulo 2^WIDTH with no overflow flag.
REQ-019 Any ALUOp value from 1100 to 1111 SHALL give res = 0.
REQ-020 MDOp SHALL decode as: 000 none; 001 MULT (signed); 010 MULTU; 011 DIV (signed); 100 DIVU; 101 MTHI; 110 MTLO; 111 reserved.
REQ-021 The block SHALL implement FSM states IDLE, MUL and DIV, with reset state IDLE.
REQ-022 In IDLE, start=1 with MULT or MULTU at edge t SHALL latch A, B and the signedness, enter MUL, and load the counter with MUL_LAT; DIV or DIVU SHALL do the same with DIV, loading DIV_LAT.
REQ-023 busy SHALL equal (state != IDLE), and so SHALL be high for exactly LAT cycles, from the edge t+1 cycle through the cycle ending at edge t+LAT.
REQ-024 At edge t+LAT the block SHALL write HI/LO and return to IDLE; HI and LO SHALL hold their old values until then.
REQ-025 Multiply SHALL produce {HI,LO} as the full 2*WIDTH-bit product, signed or unsigned per MDOp.
REQ-026 Divide SHALL produce LO = quotient truncated toward zero and HI = remainder carrying the sign of the dividend.
REQ-027 A divisor of zero SHALL still hold busy for DIV_LAT cycles and SHALL leave HI and LO unchanged.
REQ-028 Signed divide of MIN by -1 SHALL give LO = MIN and HI = 0.
REQ-029 In IDLE, start with MTHI SHALL set HI to A at that edge (MTLO: LO to A), with busy staying 0.
REQ-030 start while busy SHALL be ignored entirely: no queueing and no change to the in-flight operands.
REQ-031 start with MDOp 000 or 111 SHALL be ignored.
REQ-032 A new start SHALL be accepted in the first cycle in which busy=0, including the cycle right after completion.
REQ-033 The latched operands SHALL be used for the whole operation; changes on A/B while busy SHALL have no effect.

Reset
REQ-034 reset=1 SHALL asynchronously force the FSM to IDLE, busy to 0, HI and LO to 0, and the counter and operand latches to 0.
REQ-035 Reset during MUL or DIV SHALL abort the operation with no HI/LO write; the first start after deassertion SHALL be accepted normally.

Configuration
REQ-036 With macro MD_ALU_DIV_EN defined, the block SHALL implement DIV and DIVU as specified above.
REQ-037 Without MD_ALU_DIV_EN, MDOp 011 and 100 SHALL be ignored like 000: no busy, no HI/LO change, and no divider logic synthesised.

Verification
REQ-038 With WIDTH=32 and MUL_LAT=5: MULT A=0xFFFFFFFE (-2), B=3 -> busy high exactly 5 cycles; then HI=0xFFFFFFFF and LO=0xFFFFFFFA.
REQ-039 MULTU A=0xFFFFFFFF, B=2 -> HI=0x00000001 and LO=0xFFFFFFFE; a second start issued during busy -> no effect.
REQ-040 With DIV_LAT=10: DIV A=-7, B=2 -> after 10 busy cycles LO=0xFFFFFFFD and HI=0xFFFFFFFF; DIVU with B=0 -> 10 busy cycles and HI/LO unchanged.
REQ-041 Assert reset in cycle 3 of a DIV -> busy=0, HI=0, LO=0 immediately; after release, MTLO A=0x1234 -> LO=0x1234 next edge, busy never rising.
REQ-042 ALUOp sweep with A=5, B=0x80000000: SLT=0, SLTU=1, SRA=0xFC000000, SRL=0x04000000, LUI (B=0xABCD)=0xABCD0000, ALUOp=1111 -> 0.
REQ-043 Build without MD_ALU_DIV_EN: DIV start -> busy stays 0 and HI/LO unchanged.
